// File: rtl/mux_seq_pkg.sv
// Shared definitions for the sequential N-to-1 channel multiplexer.
//   MODE_MANUAL / MODE_SCAN : encodings of the mux_nto1_seq 'mode' input.
//   wrap_inc()              : next channel index, wrapping modulo the channel count.
package mux_seq_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Next index modulo n; idx is assumed to lie in 0..n-1.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder.
// Ports:
//   req_i   : request vector, one bit per channel
//   start_i : index the search begins at (must be < NUM_CH)
//   found_o : at least one request bit is set
//   idx_o   : first set index found searching start_i, start_i+1, ... with wrap-around
module rr_pick #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  start_i,
  output logic              found_o,
  output logic [SEL_W-1:0]  idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        // j is the channel visited at search step i
        if (!found_o && req_i[j] && ((32'(start_i) + i) % NUM_CH == j)) begin
          found_o = 1'b1;
          idx_o   = SEL_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mux_nto1_seq.sv
// Registered NUM_CH-to-1 channel multiplexer with a valid/ready output stage.
// Selection: manual (external sel) or scan (internal round-robin pointer).
// Build option: MUX_SCAN_SKIP_INVALID_EN -- when defined, scan mode skips channels
// without in_valid (round-robin via rr_pick); otherwise scan waits on ptr strictly.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : NUM_CH*WIDTH channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ack     : one-hot pulse, channel captured this cycle
//   mode, sel  : selection mode and manual-mode channel select
//   out_data, out_ch, out_valid, out_ready : registered output handshake
module mux_nto1_seq
  import mux_seq_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned NUM_CH = 16,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ack,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_ok;
  logic             man_ok;
  logic [SEL_W-1:0] scan_c;
  logic             scan_ok;
  logic [SEL_W-1:0] cand;
  logic             cand_ok;
  logic             capture;
  logic [WIDTH-1:0] cand_data;

`ifdef MUX_SCAN_SKIP_INVALID_EN
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req_i   (in_valid),
    .start_i (ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );
`endif

  always_comb begin
    load_ok = !out_valid_q || out_ready;

    // Out-of-range sel matches no channel, so man_ok stays low.
    man_ok = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (SEL_W'(k) == sel) man_ok = in_valid[k];
    end

`ifdef MUX_SCAN_SKIP_INVALID_EN
    scan_c  = rr_idx;
    scan_ok = rr_found;
`else
    scan_c  = ptr_q;
    scan_ok = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (SEL_W'(k) == ptr_q) scan_ok = in_valid[k];
    end
`endif

    cand    = (mode == MODE_SCAN) ? scan_c : sel;
    cand_ok = (mode == MODE_SCAN) ? scan_ok : man_ok;
    // Gating with rst_n keeps in_ack silent while reset is held.
    capture = rst_n && load_ok && cand_ok;

    cand_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (SEL_W'(k) == cand) cand_data = in_data[k*WIDTH +: WIDTH];
    end

    for (int unsigned k = 0; k < NUM_CH; k++) begin
      in_ack[k] = capture && (SEL_W'(k) == cand);
    end

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (capture) begin
      out_data_d  = cand_data;
      out_ch_d    = cand;
      out_valid_d = 1'b1;
      if (mode == MODE_SCAN) ptr_d = SEL_W'(wrap_inc(32'(cand), NUM_CH));
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_seq.sv
module tb_mux_nto1_seq;

  logic clk = 1'b0;
  logic rst_n;

  // 16-channel instance
  logic [127:0] a_data;
  logic [15:0]  a_valid, a_ack;
  logic         a_mode, a_ready, a_ov;
  logic [3:0]   a_sel, a_ch;
  logic [7:0]   a_out;

  // 12-channel instance
  logic [95:0]  b_data;
  logic [11:0]  b_valid, b_ack;
  logic         b_mode, b_ready, b_ov;
  logic [3:0]   b_sel, b_ch;
  logic [7:0]   b_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_nto1_seq #(.WIDTH(8), .NUM_CH(16)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_data),
    .in_valid  (a_valid),
    .in_ack    (a_ack),
    .mode      (a_mode),
    .sel       (a_sel),
    .out_data  (a_out),
    .out_ch    (a_ch),
    .out_valid (a_ov),
    .out_ready (a_ready)
  );

  mux_nto1_seq #(.WIDTH(8), .NUM_CH(12)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_data),
    .in_valid  (b_valid),
    .in_ack    (b_ack),
    .mode      (b_mode),
    .sel       (b_sel),
    .out_data  (b_out),
    .out_ch    (b_ch),
    .out_valid (b_ov),
    .out_ready (b_ready)
  );

  typedef struct {
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] valid;
    logic        ready;
    logic [15:0] ack;   // expected in_ack during the cycle
    logic        ov;    // expected out_valid after the edge
    logic [3:0]  ch;    // expected out_ch after the edge (checked when ov)
    logic [7:0]  data;  // expected out_data after the edge (checked when ov)
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input logic [3:0] s, input logic [15:0] v, input logic r,
                     input logic [15:0] ack, input logic ov, input logic [3:0] ch);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.ready = r;
    t.ack = ack; t.ov = ov; t.ch = ch; t.data = 8'hA0 + 8'(ch);
    vecs.push_back(t);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) a_data[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 12; k++) b_data[k*8 +: 8] = 8'hB0 + 8'(k);
    a_valid = '0; a_mode = 1'b0; a_sel = '0; a_ready = 1'b1;
    b_valid = '0; b_mode = 1'b0; b_sel = '0; b_ready = 1'b1;
    rst_n = 1'b0;

    // mode, sel, valid, ready -> ack, out_valid, out_ch
    add(1'b0, 4'd5, 16'h0020, 1'b1, 16'h0020, 1'b1, 4'd5);  // manual capture ch5
    add(1'b0, 4'd3, 16'h0008, 1'b0, 16'h0000, 1'b1, 4'd5);  // stall holds
    add(1'b0, 4'd3, 16'h0008, 1'b0, 16'h0000, 1'b1, 4'd5);
    add(1'b0, 4'd3, 16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3);  // released: ch3
    add(1'b0, 4'd3, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd3);  // drain
    add(1'b0, 4'd5, 16'hFFFF, 1'b0, 16'h0020, 1'b1, 4'd5);  // empty: loads without ready
    add(1'b0, 4'd6, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'd5);
    add(1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 4'd0);  // scan from ptr 0
    add(1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0002, 1'b1, 4'd1);
    add(1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0004, 1'b1, 4'd2);  // ptr now 3
`ifdef MUX_SCAN_SKIP_INVALID_EN
    add(1'b1, 4'd0, 16'h8004, 1'b1, 16'h8000, 1'b1, 4'd15);
    add(1'b1, 4'd0, 16'h8004, 1'b1, 16'h0004, 1'b1, 4'd2);
    add(1'b1, 4'd0, 16'h8004, 1'b1, 16'h8000, 1'b1, 4'd15);
    add(1'b1, 4'd0, 16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3);  // ptr 0 -> finds ch3
`else
    add(1'b1, 4'd0, 16'h8004, 1'b1, 16'h0000, 1'b0, 4'd2);  // stalls on ch3
    add(1'b1, 4'd0, 16'h8004, 1'b1, 16'h0000, 1'b0, 4'd2);
    add(1'b1, 4'd0, 16'h8004, 1'b1, 16'h0000, 1'b0, 4'd2);
    add(1'b1, 4'd0, 16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3);
`endif
    add(1'b0, 4'd0, 16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0);  // manual; ptr holds at 4
    add(1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0010, 1'b1, 4'd4);  // ptr held through manual

    #2;
    check("reset_ov", 32'(a_ov), 32'd0);
    check("reset_ch", 32'(a_ch), 32'd0);
    check("reset_data", 32'(a_out), 32'd0);
    check("reset_ack", 32'(a_ack), 32'd0);
    #10 rst_n = 1'b1;  // t=12, away from the edge
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      a_mode = vecs[i].mode; a_sel = vecs[i].sel;
      a_valid = vecs[i].valid; a_ready = vecs[i].ready;
      #2;
      check($sformatf("vec%0d_ack", i), 32'(a_ack), 32'(vecs[i].ack));
      @(posedge clk); #1;
      check($sformatf("vec%0d_ov", i), 32'(a_ov), 32'(vecs[i].ov));
      if (vecs[i].ov) begin
        check($sformatf("vec%0d_ch", i), 32'(a_ch), 32'(vecs[i].ch));
        check($sformatf("vec%0d_data", i), 32'(a_out), 32'(vecs[i].data));
      end
    end

    // Mid-stream async reset: output holds ch4, ptr is 5.
    check("pre_rst_ov", 32'(a_ov), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ov", 32'(a_ov), 32'd0);
    check("async_rst_ch", 32'(a_ch), 32'd0);
    check("async_rst_data", 32'(a_out), 32'd0);
    check("async_rst_ack", 32'(a_ack), 32'd0);
    #2 rst_n = 1'b1;
    // ptr must restart at 0
    a_mode = 1'b1; a_valid = 16'hFFFF; a_ready = 1'b1;
    #2;
    check("post_rst_ack", 32'(a_ack), 32'h0001);
    @(posedge clk); #1;
    check("post_rst_ch", 32'(a_ch), 32'd0);
    a_valid = '0;

    // 12-channel scan wrap: 0..11, 0, 1
    b_mode = 1'b1; b_valid = 12'hFFF; b_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      logic [11:0] e_ack;
      e_ack = 12'b1 << (i % 12);
      #2;
      check($sformatf("wrap%0d_ack", i), 32'(b_ack), 32'(e_ack));
      @(posedge clk); #1;
      check($sformatf("wrap%0d_ch", i), 32'(b_ch), 32'(i % 12));
      check($sformatf("wrap%0d_data", i), 32'(b_out), 32'(8'hB0 + 8'(i % 12)));
      check($sformatf("wrap%0d_ov", i), 32'(b_ov), 32'd1);
    end

    // Out-of-range select: pending word stalled, then drained; no capture.
    b_mode = 1'b0; b_sel = 4'd13; b_ready = 1'b0;
    #2;
    check("oor_stall_ack", 32'(b_ack), 32'd0);
    @(posedge clk); #1;
    check("oor_stall_ov", 32'(b_ov), 32'd1);
    check("oor_stall_ch", 32'(b_ch), 32'd1);
    b_ready = 1'b1;
    #2;
    check("oor_drain_ack", 32'(b_ack), 32'd0);
    @(posedge clk); #1;
    check("oor_drain_ov", 32'(b_ov), 32'd0);
    b_sel = 4'd12;
    #2;
    check("oor12_ack", 32'(b_ack), 32'd0);
    @(posedge clk); #1;
    check("oor12_ov", 32'(b_ov), 32'd0);
    b_sel = 4'd11;
    #2;
    check("sel11_ack", 32'(b_ack), 32'h800);
    @(posedge clk); #1;
    check("sel11_ch", 32'(b_ch), 32'd11);
    check("sel11_data", 32'(b_out), 32'hBB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
